// File: rtl/pe_edge_feeder.sv
// pe_edge_feeder: streams a buffered FP32 vector into a PE edge lane and captures its settled accumulation
module pe_edge_feeder #(
    parameter int DEPTH     = 16,
    parameter int QUIET_CYC = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_dat,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     start,
    output logic                     busy,
    output logic                     out_valid,
    output logic [31:0]              out_dat,
    input  logic                     out_ready,
    input  logic                     comp_done,
    input  logic [31:0]              accum_sum,
    input  logic                     error_bit,
    output logic [$clog2(DEPTH):0]   sent_cnt,
    output logic                     done,
    output logic [31:0]              result,
    output logic                     result_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int QW = $clog2(QUIET_CYC) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]    state;
    logic [31:0]   mem [DEPTH];
    logic [LW-1:0] len_q, len_c;
    logic [QW-1:0] quiet_cnt;
    logic          seen_low, hs, last, fire;

    // sent_cnt doubles as the read index: both clear on start and advance on each handshake
    assign len_c     = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign busy      = state != IDLE;
    assign out_valid = state == SEND;
    assign out_dat   = out_valid ? mem[sent_cnt[AW-1:0]] : '0;
    assign hs        = out_valid & out_ready;
    assign last      = sent_cnt == len_q - LW'(1);
    assign fire      = state == DRAIN && comp_done && seen_low && quiet_cnt == QW'(QUIET_CYC - 1);
    assign done      = state == FIN;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (wr_en && state == IDLE)
            mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            len_q      <= '0;
            sent_cnt   <= '0;
            seen_low   <= 1'b0;
            quiet_cnt  <= '0;
            result     <= '0;
            result_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (len_c == '0) begin
                        state      <= FIN;
                        result     <= '0;
                        result_err <= 1'b0;
                    end else begin
                        state     <= SEND;
                        len_q     <= len_c;
                        sent_cnt  <= '0;
                        seen_low  <= 1'b0;
                        quiet_cnt <= '0;
                    end
                end
                SEND: begin
                    if (!comp_done) seen_low <= 1'b1;
                    if (hs) begin
                        sent_cnt <= sent_cnt + LW'(1);
                        if (last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // a stale high level only counts once a low has been observed this run
                    if (!comp_done) begin
                        seen_low  <= 1'b1;
                        quiet_cnt <= '0;
                    end else if (seen_low) begin
                        quiet_cnt <= quiet_cnt + QW'(1);
                    end
                    if (fire) begin
                        result     <= accum_sum;
                        result_err <= error_bit;
                        state      <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
